// File: rtl/spi_master_mode0_ctrl_if.sv
// Command/serial bundle for the mode-0 SPI master.
// The master modport is the controller side; the slave modport is the command-block and slave-device side.
interface spi_master_mode0_ctrl_if;
    logic       start;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs_n;

    modport master (
        input  start, tx_data, miso,
        output rx_data, busy, done, sclk, mosi, cs_n
    );

    modport slave (
        output start, tx_data, miso,
        input  rx_data, busy, done, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_master_mode0_ctrl.sv
// Single-byte full-duplex SPI master, mode 0, with sclk half-period of CLK_DIV clk cycles.
// Defining SPI_MASTER_LSB_FIRST_EN makes both shifters run LSB first; the default is MSB first.
module spi_master_mode0_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_master_mode0_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, LEAD, SCK_HI, SCK_LO, TRAIL, DONE} state_t;

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [3:0] bit_q;
    logic [7:0] tx_q;
    logic [7:0] rx_sh_q;
    logic [7:0] rx_q;
    logic       busy_q, done_q, sclk_q, mosi_q, csn_q;

    logic       cnt_last;
    logic [7:0] tx_d;
    logic [7:0] rx_sh_d;
    logic       mosi_first_d;
    logic       mosi_next_d;

    assign cnt_last = (cnt_q == DIV_M1);

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign tx_d         = {1'b0, tx_q[7:1]};
    assign rx_sh_d      = {bus.miso, rx_sh_q[7:1]};
    assign mosi_first_d = bus.tx_data[0];
    assign mosi_next_d  = tx_q[1];
`else
    assign tx_d         = {tx_q[6:0], 1'b0};
    assign rx_sh_d      = {rx_sh_q[6:0], bus.miso};
    assign mosi_first_d = bus.tx_data[7];
    assign mosi_next_d  = tx_q[6];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            csn_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        tx_q    <= bus.tx_data;
                        mosi_q  <= mosi_first_d;
                        csn_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        rx_sh_q <= '0;
                        state_q <= LEAD;
                    end
                end
                LEAD: begin
                    if (cnt_last) begin
                        cnt_q   <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= SCK_HI;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                // miso is sampled at the end of the high phase, giving the slave CLK_DIV-1 cycles to settle
                SCK_HI: begin
                    if (cnt_last) begin
                        cnt_q   <= '0;
                        sclk_q  <= 1'b0;
                        rx_sh_q <= rx_sh_d;
                        bit_q   <= bit_q + 4'd1;
                        state_q <= SCK_LO;
                        if (bit_q != 4'd7) begin
                            tx_q   <= tx_d;
                            mosi_q <= mosi_next_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                SCK_LO: begin
                    if (cnt_last) begin
                        cnt_q <= '0;
                        if (bit_q == 4'd8) begin
                            state_q <= TRAIL;
                        end else begin
                            sclk_q  <= 1'b1;
                            state_q <= SCK_HI;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                TRAIL: begin
                    if (cnt_last) begin
                        cnt_q   <= '0;
                        rx_q    <= rx_sh_q;
                        done_q  <= 1'b1;
                        csn_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        mosi_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rx_data = rx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs_n    = csn_q;
endmodule

// File: tb/tb_spi_master_mode0_ctrl.sv
// Randomized bench for spi_master_mode0_ctrl: a byte-level model of the slave and the wire protocol
// predicts mosi bit stream, rx_data, pulse counts and done latency for CLK_DIV=4 and CLK_DIV=2 instances.
module tb_spi_master_mode0_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    spi_master_mode0_ctrl_if bus4 ();
    spi_master_mode0_ctrl_if bus2 ();

    spi_master_mode0_ctrl #(.CLK_DIV(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.master));
    spi_master_mode0_ctrl #(.CLK_DIV(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));

    assign bus2.miso = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave and line monitor: logs mosi at every sclk rise, answers one clk later.
    logic [7:0] sl_byte = 8'h00;
    int         xfer_base = 0;
    int         rise_tot = 0;
    int         done_tot = 0;
    int         cs_err = 0;
    logic       mosi_log [0:1023];
    logic       prev_sclk = 1'b0;
    logic       pend = 1'b0;
    logic       pbit = 1'b0;

    initial bus4.miso = 1'b0;

    always @(negedge clk) begin
        int k;
        if (pend) begin
            bus4.miso = pbit;
            pend = 1'b0;
        end
        if (bus4.sclk && !prev_sclk) begin
            mosi_log[rise_tot % 1024] = bus4.mosi;
            k = rise_tot - xfer_base;
            if (k >= 0 && k < 8) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
                pbit = sl_byte[k];
`else
                pbit = sl_byte[7-k];
`endif
                pend = 1'b1;
            end
            rise_tot++;
        end
        if (bus4.sclk && bus4.cs_n) cs_err++;
        if (bus4.done) done_tot++;
        prev_sclk = bus4.sclk;
    end

    task automatic xfer(input logic [7:0] tx, input logic [7:0] sl, input bit mid_start);
        int cyc, d0, c0;
        bit got;
        logic [7:0] w;
        d0 = done_tot;
        c0 = cs_err;
        sl_byte = sl;
        xfer_base = rise_tot;
        @(posedge clk); #1;
        bus4.start = 1'b1;
        bus4.tx_data = tx;
        cyc = 0;
        got = 0;
        while (cyc < 400 && !got) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                bus4.start = 1'b0;
                bus4.tx_data = 8'($urandom);
                chk("busy_on", {31'd0, bus4.busy}, 32'd1);
                chk("csn_on", {31'd0, bus4.cs_n}, 32'd0);
            end
            if (mid_start && cyc == 20) bus4.start = 1'b1;
            if (mid_start && cyc == 21) bus4.start = 1'b0;
            if (bus4.done) got = 1;
        end
        chk("latency4", cyc, 18 * 4 + 1);
        chk("rx_data", {24'd0, bus4.rx_data}, {24'd0, sl});
        @(posedge clk); #1;
        chk("done_1cyc", {31'd0, bus4.done}, 32'd0);
        chk("busy_off", {31'd0, bus4.busy}, 32'd0);
        chk("csn_off", {31'd0, bus4.cs_n}, 32'd1);
        @(negedge clk);
        #1;
        chk("pulses", rise_tot - xfer_base, 8);
        chk("done_cnt", done_tot - d0, 1);
        chk("csn_low", cs_err - c0, 0);
        for (int i = 0; i < 8; i++) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
            w[i] = mosi_log[(xfer_base + i) % 1024];
`else
            w[7-i] = mosi_log[(xfer_base + i) % 1024];
`endif
        end
        chk("mosi_bits", {24'd0, w}, {24'd0, tx});
    endtask

    initial begin
        int d0, cyc;
        bit got;
        rst_n = 1'b0;
        bus4.start = 1'b0;
        bus4.tx_data = 8'h00;
        bus2.start = 1'b0;
        bus2.tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_csn", {31'd0, bus4.cs_n}, 32'd1);
        chk("rst_sclk", {31'd0, bus4.sclk}, 32'd0);
        chk("rst_mosi", {31'd0, bus4.mosi}, 32'd0);
        chk("rst_busy", {31'd0, bus4.busy}, 32'd0);
        chk("rst_done", {31'd0, bus4.done}, 32'd0);
        chk("rst_rx", {24'd0, bus4.rx_data}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_csn", {31'd0, bus4.cs_n}, 32'd1);
        chk("idle_busy", {31'd0, bus4.busy}, 32'd0);

        xfer(8'hA5, 8'h3C, 1'b0);
        xfer(8'h55, 8'hAA, 1'b0);
        xfer(8'h00, 8'h00, 1'b0);
        xfer(8'hFF, 8'hFF, 1'b0);
        xfer(8'hC3, 8'h5A, 1'b1);
        for (int i = 0; i < 8; i++) xfer(8'($urandom), 8'($urandom), ($urandom_range(0, 1) == 1));

        // Abort mid-transfer with reset
        @(posedge clk); #1;
        bus4.start = 1'b1;
        bus4.tx_data = 8'h96;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_csn", {31'd0, bus4.cs_n}, 32'd1);
        chk("abort_sclk", {31'd0, bus4.sclk}, 32'd0);
        chk("abort_busy", {31'd0, bus4.busy}, 32'd0);
        chk("abort_rx", {24'd0, bus4.rx_data}, 32'd0);
        d0 = done_tot;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("abort_nodone", done_tot - d0, 0);
        xfer(8'h3E, 8'hD1, 1'b0);

        // CLK_DIV=2 instance latency, miso held high
        @(posedge clk); #1;
        bus2.start = 1'b1;
        bus2.tx_data = 8'h12;
        cyc = 0;
        got = 0;
        while (cyc < 200 && !got) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) bus2.start = 1'b0;
            if (bus2.done) got = 1;
        end
        chk("latency2", cyc, 18 * 2 + 1);
        chk("rx2", {24'd0, bus2.rx_data}, 32'hFF);
        @(posedge clk); #1;
        chk("done2_1cyc", {31'd0, bus2.done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
